// File: rtl/fetch_inject_stage_pkg.sv
// fetch_inject_stage_pkg: shared widths, opcode constants and fetch state encoding.
package fetch_inject_stage_pkg;
    localparam int INSTR_W = 16;
    localparam int ADDR_W = 32;
    localparam logic [2:0] IMM_OPC = 3'b101;
    localparam logic [INSTR_W-1:0] NOP_OP = 16'h0000;
    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        INJECT    = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_inject_stage_int_gate.sv
// fetch_inject_stage_int_gate: latches the external interrupt and releases it only at an opcode boundary.
module fetch_inject_stage_int_gate
    import fetch_inject_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ext_int,
    input  logic         icu_ack,
    input  fetch_state_t state,
    output logic         int_flag
);
    logic pending;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= 1'b0;
            int_flag <= 1'b0;
        end else begin
            pending  <= !icu_ack && (pending || ext_int);
            int_flag <= pending && state == FETCH_OP && !icu_ack;
        end
    end
endmodule

// File: rtl/fetch_inject_stage.sv
// fetch_inject_stage: PC and IF/ID register; merges memory fetch with ICU-injected instructions.
module fetch_inject_stage
    import fetch_inject_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'd32,
    parameter logic [2:0]        IMM_OPC  = fetch_inject_stage_pkg::IMM_OPC
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               ext_int,
    output logic               icu_int_flag,
    input  logic               icu_active,
    input  logic [INSTR_W-1:0] icu_instr,
    input  logic               icu_stall,
    input  logic               icu_ack,
    input  logic [ADDR_W-1:0]  icu_pc_value,
    input  logic               hz_stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [INSTR_W-1:0] ifid_imm,
    output logic               ifid_imm_valid,
    output logic               ifid_valid,
    output logic [ADDR_W-1:0]  ifid_pc
);
    fetch_state_t       state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx, ifid_pc_nx;
    logic [INSTR_W-1:0] op_latch, op_latch_nx, ifid_instr_nx, ifid_imm_nx;
    logic               ifid_valid_nx, ifid_imm_valid_nx, two_word;

    assign imem_addr = pc;
    assign two_word  = imem_data[15:13] == IMM_OPC;

    fetch_inject_stage_int_gate u_int_gate (
        .clk      (clk),
        .rst      (reset),
        .ext_int  (ext_int),
        .icu_ack  (icu_ack),
        .state    (state),
        .int_flag (icu_int_flag)
    );

    always_comb begin
        state_nx          = state;
        pc_nx             = pc;
        op_latch_nx       = op_latch;
        ifid_instr_nx     = ifid_instr;
        ifid_imm_nx       = ifid_imm;
        ifid_imm_valid_nx = ifid_imm_valid;
        ifid_valid_nx     = ifid_valid;
        ifid_pc_nx        = ifid_pc;
        if (br_taken) begin
            pc_nx             = br_target;
            ifid_valid_nx     = 1'b0;
            ifid_imm_valid_nx = 1'b0;
            state_nx          = icu_active ? INJECT : FETCH_OP;
        end else if (icu_ack) begin
            pc_nx         = icu_pc_value;
            ifid_valid_nx = 1'b0;
            state_nx      = FETCH_OP;
        end else if (!hz_stall) begin
            if (icu_active) begin
                // pc is frozen, so it is the return address the PUSH words save
                state_nx          = INJECT;
                ifid_instr_nx     = icu_instr;
                ifid_valid_nx     = !icu_stall;
                ifid_imm_valid_nx = 1'b0;
                ifid_pc_nx        = pc;
            end else begin
                case (state)
                    FETCH_OP: begin
                        pc_nx             = pc + 1'b1;
                        op_latch_nx       = two_word ? imem_data : op_latch;
                        state_nx          = two_word ? FETCH_IMM : FETCH_OP;
                        ifid_valid_nx     = !two_word;
                        ifid_instr_nx     = two_word ? ifid_instr : imem_data;
                        ifid_imm_valid_nx = 1'b0;
                        ifid_pc_nx        = two_word ? ifid_pc : pc + 1'b1;
                    end
                    FETCH_IMM: begin
                        pc_nx             = pc + 1'b1;
                        state_nx          = FETCH_OP;
                        ifid_instr_nx     = op_latch;
                        ifid_imm_nx       = imem_data;
                        ifid_imm_valid_nx = 1'b1;
                        ifid_valid_nx     = 1'b1;
                        ifid_pc_nx        = pc + 1'b1;
                    end
                    default: begin
                        state_nx      = FETCH_OP;
                        ifid_valid_nx = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FETCH_OP;
            pc             <= RESET_PC;
            op_latch       <= NOP_OP;
            ifid_instr     <= NOP_OP;
            ifid_imm       <= '0;
            ifid_imm_valid <= 1'b0;
            ifid_valid     <= 1'b0;
            ifid_pc        <= '0;
        end else begin
            state          <= state_nx;
            pc             <= pc_nx;
            op_latch       <= op_latch_nx;
            ifid_instr     <= ifid_instr_nx;
            ifid_imm       <= ifid_imm_nx;
            ifid_imm_valid <= ifid_imm_valid_nx;
            ifid_valid     <= ifid_valid_nx;
            ifid_pc        <= ifid_pc_nx;
        end
    end
endmodule

// File: tb/tb_fetch_inject_stage.sv
// tb_fetch_inject_stage: randomized scoreboard bench with an instruction-stream reference model and a reactive ICU.
module tb_fetch_inject_stage;
    import fetch_inject_stage_pkg::*;

    logic        clk = 1'b0, reset;
    logic [31:0] imem_addr, icu_pc_value, br_target, ifid_pc;
    logic [15:0] imem_data, icu_instr, ifid_instr, ifid_imm;
    logic        ext_int, icu_int_flag, icu_active, icu_stall, icu_ack, hz_stall, br_taken;
    logic        ifid_imm_valid, ifid_valid;

    logic [15:0] mem [0:1023];
    assign imem_data = mem[imem_addr[9:0]];

    always #5 clk = ~clk;

    fetch_inject_stage dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .ext_int(ext_int), .icu_int_flag(icu_int_flag), .icu_active(icu_active),
        .icu_instr(icu_instr), .icu_stall(icu_stall), .icu_ack(icu_ack),
        .icu_pc_value(icu_pc_value), .hz_stall(hz_stall), .br_taken(br_taken),
        .br_target(br_target), .ifid_instr(ifid_instr), .ifid_imm(ifid_imm),
        .ifid_imm_valid(ifid_imm_valid), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic        flag;
        logic        valid;
        logic        fresh;
        logic [15:0] instr;
        logic [15:0] imm;
        logic        has_imm;
        logic [31:0] ipc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0;

    // reference model: program counter, partial two-word instruction, pending interrupt
    logic [31:0] m_pc, icu_vec;
    int          m_phase;
    logic [15:0] m_op;
    logic        m_pend, m_flag, m_valid, icu_abort;
    int          icu_step;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin : mon
            exp_t e;
            e = sb.pop_front();
            chk("pc", imem_addr, e.pc);
            chk("int_flag", 32'(icu_int_flag), 32'(e.flag));
            chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
            if (e.valid && e.fresh) begin
                chk("ifid_instr", 32'(ifid_instr), 32'(e.instr));
                chk("ifid_pc", ifid_pc, e.ipc);
                chk("ifid_imm_valid", 32'(ifid_imm_valid), 32'(e.has_imm));
                if (e.has_imm) chk("ifid_imm", 32'(ifid_imm), 32'(e.imm));
            end
        end
    end

    task automatic idle_inputs();
        ext_int = 0; icu_active = 0; icu_instr = 16'(($urandom)); icu_stall = 0; icu_ack = 0;
        hz_stall = 0; br_taken = 0; br_target = 0; icu_pc_value = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        #1;
        chk("rst_pc", imem_addr, 32'd32);
        chk("rst_flag", 32'(icu_int_flag), 0);
        chk("rst_valid", 32'(ifid_valid), 0);
        chk("rst_imm_valid", 32'(ifid_imm_valid), 0);
        chk("rst_instr", 32'(ifid_instr), 0);
        chk("rst_ifid_pc", ifid_pc, 0);
        m_pc = 32; m_phase = 0; m_pend = 0; m_flag = 0; m_valid = 0; icu_step = 0;
        @(posedge clk);
        #2;
        reset = 0;
    endtask

    task automatic cycle(input logic br, input logic [31:0] tgt, input logic hz, input logic ext);
        exp_t        e;
        logic        act, stl, ack;
        logic [15:0] iw, w;
        @(negedge clk);
        if (icu_step == 0 && m_flag) icu_step = 1;
        if (icu_abort && icu_step > 0 && icu_step < 5 && $urandom_range(0, 19) == 0) icu_step = 0;
        act = icu_step != 0;
        ack = icu_step == 5;
        stl = icu_step == 1 ? 1'b1 : icu_step == 0 ? 1'($urandom_range(0, 1)) : 1'b0;
        iw  = icu_step == 1 ? NOP_OP : icu_step == 2 ? 16'h600A : icu_step == 3 ? 16'h6008 :
              icu_step == 4 ? 16'h6009 : 16'(($urandom));
        br_taken = br; br_target = tgt; hz_stall = hz; ext_int = ext;
        icu_active = act; icu_stall = stl; icu_ack = ack; icu_instr = iw; icu_pc_value = icu_vec;
        e.flag = m_pend && m_phase == 0 && !ack;
        m_pend = !ack && (m_pend || ext);
        e.fresh = 0; e.has_imm = 0; e.instr = 0; e.imm = 0; e.ipc = 0;
        if (br) begin
            m_pc = tgt; m_phase = act ? 2 : 0; m_valid = 0;
        end else if (ack) begin
            m_pc = icu_vec; m_phase = 0; m_valid = 0;
        end else if (!hz) begin
            if (act) begin
                m_phase = 2; m_valid = !stl; e.fresh = 1; e.instr = iw; e.ipc = m_pc;
            end else if (m_phase == 0) begin
                w = mem[m_pc[9:0]];
                m_pc = m_pc + 1;
                if (w[15:13] == 3'b101) begin
                    m_op = w; m_phase = 1; m_valid = 0;
                end else begin
                    m_valid = 1; e.fresh = 1; e.instr = w; e.ipc = m_pc;
                end
            end else if (m_phase == 1) begin
                e.instr = m_op; e.imm = mem[m_pc[9:0]]; e.has_imm = 1; e.fresh = 1;
                m_pc = m_pc + 1; e.ipc = m_pc; m_valid = 1; m_phase = 0;
            end else begin
                m_phase = 0; m_valid = 0;
            end
        end
        e.pc = m_pc; e.valid = m_valid; m_flag = e.flag;
        if (br || ack || !hz) icu_step = icu_step == 5 ? 0 : icu_step > 0 ? icu_step + 1 : 0;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        icu_abort = 0; icu_vec = 0; icu_step = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[32] = 16'h1234; mem[33] = 16'hA005; mem[34] = 16'h0042; mem[35] = 16'h1111;
        do_reset();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        cycle(1, 32'h100, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 40 && !(icu_step >= 2 && icu_step <= 4); i++) cycle(0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        cycle(1, 32'hFFFF_FFFE, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        icu_abort = 1;
        for (int i = 0; i < 3000; i++) begin
            logic        br, hz, ext;
            logic [31:0] tgt;
            br  = $urandom_range(0, 15) == 0;
            hz  = $urandom_range(0, 4) == 0;
            ext = $urandom_range(0, 24) == 0;
            tgt = $urandom_range(0, 9) == 0 ? 32'hFFFF_FFFD : 32'($urandom_range(0, 1023));
            if (icu_step == 0) icu_vec = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle(br, tgt, hz, ext);
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
